tournament_branch_predictor: RTL and testbench
==============================================

Name: tournament_branch_predictor

Overview:
- Parametrised full tournament predictor: gshare global PHT, two-level local predictor (local history table plus local PHT) and per-PC chooser table.
- Generalises the fixed 2-bit chooser to N-bit saturating counters.
- Adds a speculative global history register with checkpoint/restore on mispredict, and a post-reset table-initialisation FSM.
- Sits between fetch (prediction) and execute (training/recovery) in the MIPS pipeline.

Parameters:
- PHT_INDEX_BITS, 10, log2 entries of the global PHT; GHR width equals this.
- LHT_INDEX_BITS, 10, log2 entries of the local history table.
- LHR_BITS, 10, local history length; local PHT has 2^LHR_BITS entries.
- CPHT_INDEX_BITS, 10, log2 entries of the chooser table.
- CTR_BITS, 2, width of PHT saturating counters (>=2).
- CHOOSE_BITS, 2, width of chooser saturating counters (>=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ready  out  1  high once table init is complete.
- pred_req_f  in  1  fetch requests a prediction this cycle.
- pc_f  in  32  fetch PC.
- pred_taken_f  out  1  final predicted direction.
- pred_local_f  out  1  local component prediction.
- pred_global_f  out  1  global component prediction.
- pred_choice_f  out  1  chooser pick; 0 = global, 1 = local.
- pred_ghr_f  out  PHT_INDEX_BITS  GHR checkpoint, before this prediction's shift.
- upd_valid_e  in  1  resolved branch in execute.
- pc_e  in  32  execute-stage PC.
- upd_ghr_e  in  PHT_INDEX_BITS  checkpoint carried down the pipe.
- actual_taken_e  in  1  resolved direction.
- local_pred_e  in  1  local prediction carried down the pipe.
- global_pred_e  in  1  global prediction carried down the pipe.
- mispredict_e  in  1  final prediction was wrong.
- stat_pred, stat_mispred, stat_local_pick  out  32 each  statistics counters (see Optional Feature).

Behaviour:
Indexing
- gidx = pc[PHT_INDEX_BITS+1:2] XOR GHR.
- lidx = pc[LHT_INDEX_BITS+1:2]; LHR = LHT[lidx]; the local PHT is indexed by LHR.
- cidx = pc[CPHT_INDEX_BITS+1:2].
- Fetch-side indices use the speculative GHR. Execute-side gidx uses upd_ghr_e.

Prediction
- Combinational from pc_f and registered state.
- Counter predicts taken when its MSB = 1; pred_taken_f = choice ? local : global.
- All prediction outputs are 0 while ready = 0.

FSM (INIT/RUN)
- Reset: state INIT, sweep counter = 0, GHR = 0, ready = 0, stats = 0.
- INIT writes entry [sweep] of every table each cycle, for sweep = 0 .. 2^max(index widths) - 1; indices beyond a table's depth are ignored.
- Init values: PHT counters = 2^(CTR_BITS-1)-1 (weakly not-taken); chooser = 2^(CHOOSE_BITS-1) (weakly local); LHT entries = 0.
- After the last entry: RUN, ready = 1. Default INIT length is 1024 cycles.
- In INIT, pred_req_f and upd_valid_e are ignored.
- rst_n assertion at any time returns to INIT immediately and restarts the sweep.

Speculative GHR
- On pred_req_f & ready: GHR <= {GHR[PHT_INDEX_BITS-2:0], pred_taken_f}.
- On upd_valid_e & mispredict_e: GHR <= {upd_ghr_e[PHT_INDEX_BITS-2:0], actual_taken_e}.
- If both occur in the same cycle, the mispredict restore wins.

Training (upd_valid_e & ready)
- Global PHT[gidx_e] and local PHT[LHT[lidx_e]] saturate toward actual_taken_e; no wrap at 0 or max.
- LHT[lidx_e] shifts in actual_taken_e.
- Chooser[cidx_e] changes only when local_pred_e != global_pred_e: increment (saturating) if local was correct, decrement if global was correct.

Timing and hazards
- All writes occur at the clock edge.
- A same-cycle fetch of an entry being trained sees the old value; there is no bypass.

Optional Feature:
- Macro: TOURNAMENT_BP_STATS_EN.
- Defined: 32-bit wrapping counters, cleared by reset and held during INIT.
  - stat_pred counts accepted pred_req_f.
  - stat_mispred counts upd_valid_e & mispredict_e.
  - stat_local_pick counts accepted predictions with pred_choice_f = 1.
- Undefined: the stat ports exist and are tied to 0; no counter flops are synthesised.

Decomposition:
- Package tournament_bp_pkg: choice enum (CHOOSE_GLOBAL = 0, CHOOSE_LOCAL = 1), FSM state enum (BP_INIT, BP_RUN), and a parametrised saturating-update function (ctr, dir, width).
- One sub-module, bp_sat_table: single-read/single-write array of saturating counters with an init-write port. Instantiated three times: global PHT, local PHT, chooser.

Test Plan:
- Reset then idle: ready = 0 for 1024 cycles, rises on cycle 1025; first prediction at any PC gives choice = 1, taken = 0.
- Train PC 0x400 taken 2 times with local = 1, global = 0: the chooser entry saturates at 3. Train global-correct twice: chooser = 1, next pred_choice_f = 0.
- Three predictions (taken, not-taken, taken) from GHR = 0: GHR = 0b101. Then mispredict with upd_ghr_e = 0x001, actual = 1: GHR = 0x003; the restore wins over a concurrent fetch.
- Loop branch repeating T,T,T,N for 40 iterations: local prediction exact on the final 10 iterations; stat_mispred (STATS_EN) matches the bench count.
- Same-cycle fetch and update of the same index: pred reflects the pre-update counter; the next cycle reflects the update.
- rst_n low for 1 cycle mid-RUN: ready drops asynchronously, GHR = 0, init reruns, prior training lost.

Source files
------------

// File: rtl/tournament_branch_predictor_pkg.sv
// Shared types and the saturating-counter update used by every predictor table.
package tournament_bp_pkg;

  typedef enum logic {
    CHOOSE_GLOBAL = 1'b0,
    CHOOSE_LOCAL  = 1'b1
  } choice_e;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  function automatic logic [31:0] sat_update(input logic [31:0] ctr,
                                             input logic        dir,
                                             input int unsigned width);
    logic [31:0] max_v;
    max_v = (32'd1 << width) - 32'd1;
    if (dir) begin
      return (ctr >= max_v) ? max_v : ctr + 32'd1;
    end else begin
      return (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    end
  endfunction

endpackage

// File: rtl/tournament_branch_predictor_if.sv
// Fetch/execute-facing bundle of the tournament predictor; master = pipeline, slave = predictor.
interface tournament_branch_predictor_if #(
  parameter int PHT_INDEX_BITS = 10
);
  logic                      ready;
  logic                      pred_req_f;
  logic [31:0]               pc_f;
  logic                      pred_taken_f;
  logic                      pred_local_f;
  logic                      pred_global_f;
  logic                      pred_choice_f;
  logic [PHT_INDEX_BITS-1:0] pred_ghr_f;
  logic                      upd_valid_e;
  logic [31:0]               pc_e;
  logic [PHT_INDEX_BITS-1:0] upd_ghr_e;
  logic                      actual_taken_e;
  logic                      local_pred_e;
  logic                      global_pred_e;
  logic                      mispredict_e;
  logic [31:0]               stat_pred;
  logic [31:0]               stat_mispred;
  logic [31:0]               stat_local_pick;

  modport master (
    input  ready, pred_taken_f, pred_local_f, pred_global_f, pred_choice_f, pred_ghr_f,
           stat_pred, stat_mispred, stat_local_pick,
    output pred_req_f, pc_f, upd_valid_e, pc_e, upd_ghr_e, actual_taken_e,
           local_pred_e, global_pred_e, mispredict_e
  );

  modport slave (
    output ready, pred_taken_f, pred_local_f, pred_global_f, pred_choice_f, pred_ghr_f,
           stat_pred, stat_mispred, stat_local_pick,
    input  pred_req_f, pc_f, upd_valid_e, pc_e, upd_ghr_e, actual_taken_e,
           local_pred_e, global_pred_e, mispredict_e
  );
endinterface

// File: rtl/tournament_branch_predictor_bp_sat_table.sv
// Array of saturating counters: one combinational read, one read-modify-write update
// port, and an init-write port driven by the predictor's post-reset sweep.
module bp_sat_table
  import tournament_bp_pkg::*;
#(
  parameter int             IDX_BITS   = 10,
  parameter int             W          = 2,
  parameter int             SWEEP_BITS = 10,
  parameter logic [W-1:0]   INIT_VAL   = '0
) (
  input  logic                  clk,
  input  logic [IDX_BITS-1:0]   rd_idx_i,
  output logic [W-1:0]          rd_data_o,
  input  logic                  upd_en_i,
  input  logic [IDX_BITS-1:0]   upd_idx_i,
  input  logic                  upd_dir_i,
  input  logic                  init_en_i,
  input  logic [SWEEP_BITS-1:0] init_idx_i
);
  localparam int DEPTH = 1 << IDX_BITS;

  logic [W-1:0] mem_q [DEPTH];
  logic         init_hit_s;

  assign rd_data_o = mem_q[rd_idx_i];
  // Sweep positions past this table's depth belong to larger tables only.
  assign init_hit_s = ((init_idx_i >> IDX_BITS) == '0);

  // Counter storage: init sweep write, else saturating training update.
  always_ff @(posedge clk) begin
    if (init_en_i && init_hit_s) begin
      mem_q[init_idx_i[IDX_BITS-1:0]] <= INIT_VAL;
    end else if (upd_en_i) begin
      mem_q[upd_idx_i] <= W'(sat_update(32'(mem_q[upd_idx_i]), upd_dir_i, W));
    end
  end
endmodule

// File: rtl/tournament_branch_predictor.sv
// Tournament predictor: gshare global PHT, two-level local predictor, per-PC chooser,
// speculative GHR with mispredict restore. Optional stats under TOURNAMENT_BP_STATS_EN.
module tournament_branch_predictor
  import tournament_bp_pkg::*;
#(
  parameter int PHT_INDEX_BITS  = 10,
  parameter int LHT_INDEX_BITS  = 10,
  parameter int LHR_BITS        = 10,
  parameter int CPHT_INDEX_BITS = 10,
  parameter int CTR_BITS        = 2,
  parameter int CHOOSE_BITS     = 2
) (
  input logic clk,
  input logic rst_n,
  tournament_branch_predictor_if.slave bp
);
  localparam int MAX_A      = (PHT_INDEX_BITS > LHT_INDEX_BITS) ? PHT_INDEX_BITS : LHT_INDEX_BITS;
  localparam int MAX_B      = (LHR_BITS > CPHT_INDEX_BITS) ? LHR_BITS : CPHT_INDEX_BITS;
  localparam int SWEEP_BITS = (MAX_A > MAX_B) ? MAX_A : MAX_B;

  bp_state_e                  state_q, state_d;
  logic [SWEEP_BITS-1:0]      sweep_q, sweep_d;
  logic [PHT_INDEX_BITS-1:0]  ghr_q, ghr_d;
  logic [LHR_BITS-1:0]        lht_q [1 << LHT_INDEX_BITS];

  logic                       ready_s, init_en_s, train_s;
  logic [PHT_INDEX_BITS-1:0]  gidx_f_s, gidx_e_s;
  logic [LHT_INDEX_BITS-1:0]  lidx_f_s, lidx_e_s;
  logic [CPHT_INDEX_BITS-1:0] cidx_f_s, cidx_e_s;
  logic [LHR_BITS-1:0]        lhr_f_s, lhr_e_s;
  logic [CTR_BITS-1:0]        gctr_s, lctr_s;
  logic [CHOOSE_BITS-1:0]     cctr_s;
  logic                       glob_s, loc_s, taken_s;
  choice_e                    choice_s;
  logic                       unused_pc_s;

  assign ready_s   = (state_q == BP_RUN);
  assign init_en_s = (state_q == BP_INIT);
  assign train_s   = bp.upd_valid_e & ready_s;

  assign gidx_f_s = bp.pc_f[PHT_INDEX_BITS+1:2] ^ ghr_q;
  assign lidx_f_s = bp.pc_f[LHT_INDEX_BITS+1:2];
  assign cidx_f_s = bp.pc_f[CPHT_INDEX_BITS+1:2];
  assign lhr_f_s  = lht_q[lidx_f_s];
  assign gidx_e_s = bp.pc_e[PHT_INDEX_BITS+1:2] ^ bp.upd_ghr_e;
  assign lidx_e_s = bp.pc_e[LHT_INDEX_BITS+1:2];
  assign cidx_e_s = bp.pc_e[CPHT_INDEX_BITS+1:2];
  assign lhr_e_s  = lht_q[lidx_e_s];
  assign unused_pc_s = ^{bp.pc_f, bp.pc_e};

  bp_sat_table #(.IDX_BITS(PHT_INDEX_BITS), .W(CTR_BITS), .SWEEP_BITS(SWEEP_BITS),
                 .INIT_VAL(CTR_BITS'((1 << (CTR_BITS-1)) - 1))) u_gpht (
    .clk(clk), .rd_idx_i(gidx_f_s), .rd_data_o(gctr_s),
    .upd_en_i(train_s), .upd_idx_i(gidx_e_s), .upd_dir_i(bp.actual_taken_e),
    .init_en_i(init_en_s), .init_idx_i(sweep_q));

  bp_sat_table #(.IDX_BITS(LHR_BITS), .W(CTR_BITS), .SWEEP_BITS(SWEEP_BITS),
                 .INIT_VAL(CTR_BITS'((1 << (CTR_BITS-1)) - 1))) u_lpht (
    .clk(clk), .rd_idx_i(lhr_f_s), .rd_data_o(lctr_s),
    .upd_en_i(train_s), .upd_idx_i(lhr_e_s), .upd_dir_i(bp.actual_taken_e),
    .init_en_i(init_en_s), .init_idx_i(sweep_q));

  // Chooser only learns when the components disagreed; up means local was right.
  bp_sat_table #(.IDX_BITS(CPHT_INDEX_BITS), .W(CHOOSE_BITS), .SWEEP_BITS(SWEEP_BITS),
                 .INIT_VAL(CHOOSE_BITS'(1 << (CHOOSE_BITS-1)))) u_cpht (
    .clk(clk), .rd_idx_i(cidx_f_s), .rd_data_o(cctr_s),
    .upd_en_i(train_s & (bp.local_pred_e != bp.global_pred_e)), .upd_idx_i(cidx_e_s),
    .upd_dir_i(bp.local_pred_e == bp.actual_taken_e),
    .init_en_i(init_en_s), .init_idx_i(sweep_q));

  assign glob_s   = gctr_s[CTR_BITS-1];
  assign loc_s    = lctr_s[CTR_BITS-1];
  assign choice_s = choice_e'(cctr_s[CHOOSE_BITS-1]);
  assign taken_s  = (choice_s == CHOOSE_LOCAL) ? loc_s : glob_s;

  assign bp.ready         = ready_s;
  assign bp.pred_taken_f  = ready_s & taken_s;
  assign bp.pred_local_f  = ready_s & loc_s;
  assign bp.pred_global_f = ready_s & glob_s;
  assign bp.pred_choice_f = ready_s & (choice_s == CHOOSE_LOCAL);
  assign bp.pred_ghr_f    = ready_s ? ghr_q : '0;

  // Init sweep sequencing and the INIT -> RUN transition.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      BP_INIT: begin
        sweep_d = sweep_q + SWEEP_BITS'(1);
        if (sweep_q == '1) state_d = BP_RUN;
        else               state_d = BP_INIT;
      end
      BP_RUN: begin
        sweep_d = '0;
        state_d = BP_RUN;
      end
      default: begin
        sweep_d = '0;
        state_d = BP_INIT;
      end
    endcase
  end

  // Speculative GHR; a resolved mispredict overrides a same-cycle fetch shift.
  always_comb begin
    ghr_d = ghr_q;
    if (train_s && bp.mispredict_e) begin
      ghr_d = {bp.upd_ghr_e[PHT_INDEX_BITS-2:0], bp.actual_taken_e};
    end else if (ready_s && bp.pred_req_f) begin
      ghr_d = {ghr_q[PHT_INDEX_BITS-2:0], taken_s};
    end else begin
      ghr_d = ghr_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BP_INIT;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ghr_q   <= ghr_d;
    end
  end

  // Local history table: cleared by the sweep, shifted on every resolved branch.
  always_ff @(posedge clk) begin
    if (init_en_s && ((sweep_q >> LHT_INDEX_BITS) == '0)) begin
      lht_q[sweep_q[LHT_INDEX_BITS-1:0]] <= '0;
    end else if (train_s) begin
      lht_q[lidx_e_s] <= {lhr_e_s[LHR_BITS-2:0], bp.actual_taken_e};
    end
  end

`ifdef TOURNAMENT_BP_STATS_EN
  logic [31:0] stat_pred_q, stat_mispred_q, stat_local_pick_q;

  // Wrapping event counters, frozen while the tables are being initialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pred_q       <= 32'd0;
      stat_mispred_q    <= 32'd0;
      stat_local_pick_q <= 32'd0;
    end else if (ready_s) begin
      if (bp.pred_req_f) stat_pred_q <= stat_pred_q + 32'd1;
      if (bp.upd_valid_e && bp.mispredict_e) stat_mispred_q <= stat_mispred_q + 32'd1;
      if (bp.pred_req_f && (choice_s == CHOOSE_LOCAL))
        stat_local_pick_q <= stat_local_pick_q + 32'd1;
    end
  end

  assign bp.stat_pred       = stat_pred_q;
  assign bp.stat_mispred    = stat_mispred_q;
  assign bp.stat_local_pick = stat_local_pick_q;
`else
  assign bp.stat_pred       = 32'd0;
  assign bp.stat_mispred    = 32'd0;
  assign bp.stat_local_pick = 32'd0;
`endif

endmodule

// File: tb/tb_tournament_branch_predictor.sv
// Directed self-checking bench for tournament_branch_predictor (default parameters).
module tb_tournament_branch_predictor;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_loop_pred = 0;
  int   n_loop_mis  = 0;

  tournament_branch_predictor_if #(.PHT_INDEX_BITS(10)) bp();

  tournament_branch_predictor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fetch(input logic [31:0] pc, input logic req);
    bp.pc_f       = pc;
    bp.pred_req_f = req;
    #1;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic [9:0] ghr,
                           input logic act, input logic loc, input logic glb, input logic mis);
    bp.upd_valid_e    = 1'b1;
    bp.pc_e           = pc;
    bp.upd_ghr_e      = ghr;
    bp.actual_taken_e = act;
    bp.local_pred_e   = loc;
    bp.global_pred_e  = glb;
    bp.mispredict_e   = mis;
  endtask

  task automatic clear_upd();
    bp.upd_valid_e  = 1'b0;
    bp.mispredict_e = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic [9:0] ghr,
                       input logic act, input logic loc, input logic glb, input logic mis);
    drive_upd(pc, ghr, act, loc, glb, mis);
    tick();
    clear_upd();
  endtask

  task automatic wait_ready(input string name);
    int cycles = 0;
    while (!bp.ready && cycles < 2000) begin
      tick();
      cycles++;
    end
    n_cmp++;
    if (cycles !== 1024) begin
      n_fail++;
      $display("FAIL %s: ready after %0d cycles, expected 1024", name, cycles);
    end
  endtask

  task automatic test_reset();
    bp.pred_req_f = 1'b0; bp.pc_f = 32'h0; clear_upd();
    bp.pc_e = 32'h0; bp.upd_ghr_e = 10'h0; bp.actual_taken_e = 1'b0;
    bp.local_pred_e = 1'b0; bp.global_pred_e = 1'b0;
    #2;
    n_cmp++;
    if (bp.ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %0b expected 0", bp.ready);
    end
    n_cmp++;
    if (bp.pred_choice_f !== 1'b0 || bp.pred_ghr_f !== 10'h0) begin
      n_fail++; $display("FAIL reset_outputs_zero: choice %0b ghr %0h expected 0 0",
                         bp.pred_choice_f, bp.pred_ghr_f);
    end
    #10 rst_n = 1'b1;
    wait_ready("init_length");
    drive_fetch(32'h1234, 1'b0);
    n_cmp++;
    if (bp.pred_choice_f !== 1'b1 || bp.pred_taken_f !== 1'b0) begin
      n_fail++; $display("FAIL first_pred: choice %0b taken %0b expected 1 0",
                         bp.pred_choice_f, bp.pred_taken_f);
    end
    n_cmp++;
    if (bp.pred_ghr_f !== 10'h0 || bp.stat_pred !== 32'd0) begin
      n_fail++; $display("FAIL ghr_stats_after_init: ghr %0h stat_pred %0d expected 0 0",
                         bp.pred_ghr_f, bp.stat_pred);
    end
  endtask

  task automatic test_chooser();
    train(32'h400, 10'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    train(32'h400, 10'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_fetch(32'h400, 1'b0);
    n_cmp++;
    if (bp.pred_choice_f !== 1'b1) begin
      n_fail++; $display("FAIL chooser_local_sat: got %0b expected 1", bp.pred_choice_f);
    end
    n_cmp++;
    if (bp.pred_global_f !== 1'b1) begin
      n_fail++; $display("FAIL gpht_trained_taken: got %0b expected 1", bp.pred_global_f);
    end
    train(32'h400, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_fetch(32'h400, 1'b0);
    n_cmp++;
    if (bp.pred_choice_f !== 1'b1) begin
      n_fail++; $display("FAIL chooser_3_to_2: got %0b expected 1", bp.pred_choice_f);
    end
    train(32'h400, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_fetch(32'h400, 1'b0);
    n_cmp++;
    if (bp.pred_choice_f !== 1'b0 || bp.pred_taken_f !== 1'b0) begin
      n_fail++; $display("FAIL chooser_global_pick: choice %0b taken %0b expected 0 0",
                         bp.pred_choice_f, bp.pred_taken_f);
    end
  endtask

  task automatic test_ghr();
    logic [31:0] e_pred, e_mis, e_lp;
    // PC 0x800 taught global-taken under GHR 0 and GHR 2, chooser driven to global.
    train(32'h800, 10'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    train(32'h800, 10'h2, 1'b1, 1'b0, 1'b1, 1'b0);
    drive_fetch(32'h800, 1'b1);
    n_cmp++;
    if (bp.pred_taken_f !== 1'b1 || bp.pred_ghr_f !== 10'h0) begin
      n_fail++; $display("FAIL ghr_pred1: taken %0b ghr %0h expected 1 0", bp.pred_taken_f, bp.pred_ghr_f);
    end
    tick();
    drive_fetch(32'h400, 1'b1);
    n_cmp++;
    if (bp.pred_taken_f !== 1'b0 || bp.pred_ghr_f !== 10'h1) begin
      n_fail++; $display("FAIL ghr_pred2: taken %0b ghr %0h expected 0 1", bp.pred_taken_f, bp.pred_ghr_f);
    end
    tick();
    drive_fetch(32'h800, 1'b1);
    n_cmp++;
    if (bp.pred_taken_f !== 1'b1 || bp.pred_ghr_f !== 10'h2) begin
      n_fail++; $display("FAIL ghr_pred3: taken %0b ghr %0h expected 1 2", bp.pred_taken_f, bp.pred_ghr_f);
    end
    tick();
    drive_fetch(32'h800, 1'b0);
    n_cmp++;
    if (bp.pred_ghr_f !== 10'h5) begin
      n_fail++; $display("FAIL ghr_after_three: got %0h expected 5", bp.pred_ghr_f);
    end
    drive_fetch(32'hC00, 1'b1);
    train(32'hC00, 10'h1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive_fetch(32'hC00, 1'b0);
    n_cmp++;
    if (bp.pred_ghr_f !== 10'h3) begin
      n_fail++; $display("FAIL ghr_restore_wins: got %0h expected 3", bp.pred_ghr_f);
    end
`ifdef TOURNAMENT_BP_STATS_EN
    e_pred = 32'd4; e_mis = 32'd1; e_lp = 32'd1;
`else
    e_pred = 32'd0; e_mis = 32'd0; e_lp = 32'd0;
`endif
    n_cmp++;
    if (bp.stat_pred !== e_pred || bp.stat_mispred !== e_mis || bp.stat_local_pick !== e_lp) begin
      n_fail++; $display("FAIL stats_ghr: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         bp.stat_pred, bp.stat_mispred, bp.stat_local_pick, e_pred, e_mis, e_lp);
    end
  endtask

  task automatic test_same_cycle();
    // GHR is 3, so PC 0x0F0 maps to global entry 0x3F (still weakly not-taken).
    drive_fetch(32'h0F0, 1'b0);
    drive_upd(32'h0F0, 10'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (bp.pred_global_f !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle_old_inc: got %0b expected 0", bp.pred_global_f);
    end
    tick();
    clear_upd();
    n_cmp++;
    if (bp.pred_global_f !== 1'b1) begin
      n_fail++; $display("FAIL next_cycle_new_inc: got %0b expected 1", bp.pred_global_f);
    end
    drive_upd(32'h0F0, 10'h3, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (bp.pred_global_f !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_old_dec: got %0b expected 1", bp.pred_global_f);
    end
    tick();
    clear_upd();
    n_cmp++;
    if (bp.pred_global_f !== 1'b0) begin
      n_fail++; $display("FAIL next_cycle_new_dec: got %0b expected 0", bp.pred_global_f);
    end
  endtask

  task automatic test_loop();
    logic       act, loc, glb, tk, mis;
    logic [9:0] g;
    logic [31:0] e_pred, e_mis;
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 4; k++) begin
        act = (k != 3);
        drive_fetch(32'h1F00, 1'b1);
        loc = bp.pred_local_f; glb = bp.pred_global_f; tk = bp.pred_taken_f; g = bp.pred_ghr_f;
        n_loop_pred++;
        if (it >= 30) begin
          n_cmp++;
          if (loc !== act) begin
            n_fail++; $display("FAIL loop_local it%0d k%0d: got %0b expected %0b", it, k, loc, act);
          end
        end
        tick();
        bp.pred_req_f = 1'b0;
        mis = (tk != act);
        if (mis) n_loop_mis++;
        train(32'h1F00, g, act, loc, glb, mis);
      end
    end
`ifdef TOURNAMENT_BP_STATS_EN
    e_pred = 32'd4 + 32'(n_loop_pred); e_mis = 32'd1 + 32'(n_loop_mis);
`else
    e_pred = 32'd0; e_mis = 32'd0;
`endif
    n_cmp++;
    if (bp.stat_pred !== e_pred || bp.stat_mispred !== e_mis) begin
      n_fail++; $display("FAIL stats_loop: got %0d/%0d expected %0d/%0d",
                         bp.stat_pred, bp.stat_mispred, e_pred, e_mis);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bp.ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_async: ready %0b expected 0", bp.ready);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    wait_ready("reinit_length");
    drive_fetch(32'h800, 1'b0);
    n_cmp++;
    if (bp.pred_ghr_f !== 10'h0 || bp.stat_pred !== 32'd0) begin
      n_fail++; $display("FAIL mid_reset_ghr_stats: ghr %0h stat_pred %0d expected 0 0",
                         bp.pred_ghr_f, bp.stat_pred);
    end
    n_cmp++;
    if (bp.pred_choice_f !== 1'b1 || bp.pred_taken_f !== 1'b0 || bp.pred_global_f !== 1'b0) begin
      n_fail++; $display("FAIL training_lost: choice %0b taken %0b global %0b expected 1 0 0",
                         bp.pred_choice_f, bp.pred_taken_f, bp.pred_global_f);
    end
  endtask

  initial begin
    test_reset();
    test_chooser();
    test_ghr();
    test_same_cycle();
    test_loop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
